// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes, protection bit positions and address helpers
// used by the register file and its decoder.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    localparam int PROT_PRIV = 0;

    function automatic int addrLsb(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite channel bundle (AW, W, B, AR, R) with master and slave views.
interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [2:0]                aw_prot;
    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic                      b_valid;
    logic                      b_ready;
    axi_lite_pkg::resp_t       b_resp;
    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [2:0]                ar_prot;
    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    axi_lite_pkg::resp_t       r_resp;

    modport slave (
        input  aw_valid, aw_addr, aw_prot, output aw_ready,
        input  w_valid, w_data, w_strb, output w_ready,
        output b_valid, b_resp, input b_ready,
        input  ar_valid, ar_addr, ar_prot, output ar_ready,
        output r_valid, r_data, r_resp, input r_ready
    );

    modport master (
        output aw_valid, aw_addr, aw_prot, input aw_ready,
        output w_valid, w_data, w_strb, input w_ready,
        input  b_valid, b_resp, output b_ready,
        output ar_valid, ar_addr, ar_prot, input ar_ready,
        input  r_valid, r_data, r_resp, output r_ready
    );
endinterface

// File: rtl/axi_lite_regfile_decode.sv
// Address/protection decoder: register index and response code for one access.
// Unprivileged accesses are refused only when AXI_LITE_REGFILE_PROT_EN is defined.
module axi_lite_regfile_decode
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            prot_i,
    output logic [IDX_W-1:0]      idx_o,
    output resp_t                 resp_o
);

    localparam int ADDR_LSB = addrLsb(DATA_WIDTH);
    localparam int FULL_W   = ADDR_WIDTH - ADDR_LSB;

    logic [FULL_W-1:0] idxFull;
    logic              inRange;
    logic              unusedBits;

    // The range test uses every upper address bit so aliases above NUM_REGS decode as errors.
    assign idxFull = addr_i[ADDR_WIDTH-1:ADDR_LSB];
    assign idx_o   = idxFull[IDX_W-1:0];
    assign inRange = idxFull < FULL_W'(NUM_REGS);

    always_comb begin
        resp_o = RESP_OKAY;
        if (!inRange)
            resp_o = RESP_DECERR;
`ifdef AXI_LITE_REGFILE_PROT_EN
        else if (!prot_i[PROT_PRIV])
            resp_o = RESP_SLVERR;
`endif
    end

`ifdef AXI_LITE_REGFILE_PROT_EN
    assign unusedBits = ^{addr_i[ADDR_LSB-1:0], prot_i[2:1]};
`else
    assign unusedBits = ^{addr_i[ADDR_LSB-1:0], prot_i};
`endif

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite CSR endpoint: NUM_REGS byte-strobe writable registers with write pulses.
// Define AXI_LITE_REGFILE_PROT_EN to answer unprivileged accesses with SLVERR.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    axi_lite_channel.slave                 master,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  awHeld_q, wHeld_q;
    logic [ADDR_WIDTH-1:0] awAddr_q;
    logic [2:0]            awProt_q;
    logic [DATA_WIDTH-1:0] wData_q;
    logic [STRB_W-1:0]     wStrb_q;
    logic                  bValid_q;
    resp_t                 bResp_q;
    logic                  rValid_q;
    logic [DATA_WIDTH-1:0] rData_q, rData_d;
    resp_t                 rResp_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   wrPulse_q, wrPulse_d;

    logic       awHs, wHs, arHs, commit;
    logic [IDX_W-1:0] wrIdx, rdIdx;
    resp_t      wrResp, rdResp;

    assign awHs   = master.aw_valid && !awHeld_q;
    assign wHs    = master.w_valid && !wHeld_q;
    assign arHs   = master.ar_valid && master.ar_ready;
    // A pending B holds off the commit, but new AW/W beats may still be captured.
    assign commit = awHeld_q && wHeld_q && !bValid_q;

    axi_lite_regfile_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)
    ) wrDecode (
        .addr_i(awAddr_q), .prot_i(awProt_q), .idx_o(wrIdx), .resp_o(wrResp)
    );

    axi_lite_regfile_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)
    ) rdDecode (
        .addr_i(master.ar_addr), .prot_i(master.ar_prot), .idx_o(rdIdx), .resp_o(rdResp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awHeld_q <= 1'b0;
            wHeld_q  <= 1'b0;
            awAddr_q <= '0;
            awProt_q <= '0;
            wData_q  <= '0;
            wStrb_q  <= '0;
        end else begin
            if (awHs) begin
                awHeld_q <= 1'b1;
                awAddr_q <= master.aw_addr;
                awProt_q <= master.aw_prot;
            end else if (commit) begin
                awHeld_q <= 1'b0;
            end
            if (wHs) begin
                wHeld_q <= 1'b1;
                wData_q <= master.w_data;
                wStrb_q <= master.w_strb;
            end else if (commit) begin
                wHeld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bValid_q <= 1'b0;
            bResp_q  <= RESP_OKAY;
        end else if (commit) begin
            bValid_q <= 1'b1;
            bResp_q  <= wrResp;
        end else if (master.b_ready) begin
            bValid_q <= 1'b0;
        end
    end

    always_comb begin
        wrPulse_d = '0;
        if (commit && wrResp == RESP_OKAY) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wrIdx == IDX_W'(i))
                    wrPulse_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= RESET_VALUE;
        end else begin
            wrPulse_q <= wrPulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wrPulse_d[i]) begin
                    for (int k = 0; k < STRB_W; k++) begin
                        if (wStrb_q[k])
                            regs_q[i][8*k +: 8] <= wData_q[8*k +: 8];
                    end
                end
            end
        end
    end

    // Reads sample regs_q before this edge's write, so a same-cycle read sees the old value.
    always_comb begin
        rData_d = '0;
        if (rdResp == RESP_OKAY) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rdIdx == IDX_W'(i))
                    rData_d = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rValid_q <= 1'b0;
            rData_q  <= '0;
            rResp_q  <= RESP_OKAY;
        end else if (arHs) begin
            rValid_q <= 1'b1;
            rData_q  <= rData_d;
            rResp_q  <= rdResp;
        end else if (master.r_ready) begin
            rValid_q <= 1'b0;
        end
    end

    assign master.aw_ready = !awHeld_q;
    assign master.w_ready  = !wHeld_q;
    assign master.b_valid  = bValid_q;
    assign master.b_resp   = bResp_q;
    assign master.ar_ready = !rValid_q || master.r_ready;
    assign master.r_valid  = rValid_q;
    assign master.r_data   = rData_q;
    assign master.r_resp   = rResp_q;
    assign wr_pulse        = wrPulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : gRegs
        assign regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed scoreboard bench for axi_lite_regfile (16 x 32-bit registers).
// Stimulus pushes expected B/R/pulse responses; a negedge monitor pops and compares them.
module tb_axi_lite_regfile;
    import axi_lite_pkg::*;

`ifdef AXI_LITE_REGFILE_PROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef struct packed {
        resp_t       resp;
        logic [31:0] data;
    } rExp_t;

    logic          clk;
    logic          rst;
    logic [511:0]  regs;
    logic [15:0]   wr_pulse;

    axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .RESET_VALUE(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .master(bus), .regs(regs), .wr_pulse(wr_pulse)
    );

    int          checks = 0;
    int          errors = 0;
    int          bSeen  = 0;
    resp_t       bExpQ[$];
    rExp_t       rExpQ[$];
    logic [15:0] pulseExpQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] regAt(input int i);
        return regs[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectWrite(input resp_t resp, input logic [15:0] pulse);
        bExpQ.push_back(resp);
        if (pulse != 16'h0)
            pulseExpQ.push_back(pulse);
    endtask

    task automatic expectRead(input resp_t resp, input logic [31:0] data);
        rExpQ.push_back('{resp: resp, data: data});
    endtask

    // Drives AW and/or W and returns one step after every requested handshake.
    task automatic writeXact(input bit doAw, input bit doW, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
        bit awPend = doAw;
        bit wPend  = doW;
        bit awHs, wHs;
        int n = 0;
        if (doAw) begin
            bus.aw_valid = 1'b1; bus.aw_addr = addr; bus.aw_prot = prot;
        end
        if (doW) begin
            bus.w_valid = 1'b1; bus.w_data = data; bus.w_strb = strb;
        end
        #1;
        while ((awPend || wPend) && n < 20) begin
            awHs = awPend && bus.aw_ready;
            wHs  = wPend && bus.w_ready;
            tick();
            n++;
            if (awHs) begin bus.aw_valid = 1'b0; awPend = 1'b0; end
            if (wHs)  begin bus.w_valid  = 1'b0; wPend  = 1'b0; end
        end
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        checkOutput("wr_handshake_timeout", {63'b0, awPend || wPend}, 64'd0);
    endtask

    task automatic readXact(input logic [31:0] addr, input logic [2:0] prot);
        bit pend = 1'b1;
        bit hs;
        int n = 0;
        bus.ar_valid = 1'b1; bus.ar_addr = addr; bus.ar_prot = prot;
        #1;
        while (pend && n < 20) begin
            hs = bus.ar_ready;
            tick();
            n++;
            if (hs) begin bus.ar_valid = 1'b0; pend = 1'b0; end
        end
        bus.ar_valid = 1'b0;
        checkOutput("ar_handshake_timeout", {63'b0, pend}, 64'd0);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            tick();
            done = bExpQ.size() == 0 && rExpQ.size() == 0 && pulseExpQ.size() == 0
                   && !bus.b_valid && !bus.r_valid;
        end
        checkOutput("drain_timeout", {63'b0, done}, 64'd1);
    endtask

    // Scoreboard monitor: samples mid-cycle, where a valid&&ready pair will handshake at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.b_valid && bus.b_ready) begin
                bSeen++;
                if (bExpQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL b_spurious actual=resp 0x%0h expected=no response", bus.b_resp);
                end else begin
                    checkOutput("b_resp", 64'(bus.b_resp), 64'(bExpQ.pop_front()));
                end
            end
            if (bus.r_valid && bus.r_ready) begin
                if (rExpQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL r_spurious actual=data 0x%0h expected=no response", bus.r_data);
                end else begin
                    rExp_t e;
                    e = rExpQ.pop_front();
                    checkOutput("r_resp", 64'(bus.r_resp), 64'(e.resp));
                    checkOutput("r_data", 64'(bus.r_data), 64'(e.data));
                end
            end
            if (wr_pulse != 16'h0) begin
                if (pulseExpQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL pulse_spurious actual=0x%0h expected=0x0", wr_pulse);
                end else begin
                    checkOutput("wr_pulse", 64'(wr_pulse), 64'(pulseExpQ.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus();
        logic [31:0] expRegs [16];
        int          bBefore;
        foreach (expRegs[i]) expRegs[i] = 32'h0;

        // Reset state
        checkOutput("rst_b_valid", 64'(bus.b_valid), 64'd0);
        checkOutput("rst_r_valid", 64'(bus.r_valid), 64'd0);
        checkOutput("rst_r_data", 64'(bus.r_data), 64'd0);
        checkOutput("rst_b_resp", 64'(bus.b_resp), 64'd0);
        checkOutput("rst_aw_ready", 64'(bus.aw_ready), 64'd1);
        checkOutput("rst_w_ready", 64'(bus.w_ready), 64'd1);
        checkOutput("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("rst_reg%0d", i), 64'(regAt(i)), 64'd0);

        // 1: AW+W together to reg2
        expectWrite(RESP_OKAY, 16'h0004);
        writeXact(1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 3'b001);
        checkOutput("t1_b_valid_commit_cycle", 64'(bus.b_valid), 64'd0);
        tick();
        checkOutput("t1_b_valid", 64'(bus.b_valid), 64'd1);
        checkOutput("t1_wr_pulse", 64'(wr_pulse), 64'h4);
        checkOutput("t1_reg2", 64'(regAt(2)), 64'hDEADBEEF);
        drain();
        expRegs[2] = 32'hDEADBEEF;

        // 2: preload reg1, then W before AW with sparse strobes
        expectWrite(RESP_OKAY, 16'h0002);
        writeXact(1'b1, 1'b1, 32'h4, 32'hAABBCCDD, 4'hF, 3'b001);
        drain();
        bBefore = bSeen;
        expectWrite(RESP_OKAY, 16'h0002);
        writeXact(1'b0, 1'b1, 32'h0, 32'h11223344, 4'h5, 3'b001);
        tick();
        checkOutput("t2_no_commit_without_aw", 64'(bus.b_valid), 64'd0);
        checkOutput("t2_w_ready_held", 64'(bus.w_ready), 64'd0);
        writeXact(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 3'b001);
        drain();
        checkOutput("t2_reg1", 64'(regAt(1)), 64'hAA22CC44);
        checkOutput("t2_one_b", 64'(bSeen - bBefore), 64'd1);
        expRegs[1] = 32'hAA22CC44;

        // 3: B back-pressure blocks the second commit but not its capture
        bus.b_ready = 1'b0;
        expectWrite(RESP_OKAY, 16'h0008);
        writeXact(1'b1, 1'b1, 32'hC, 32'h000000C3, 4'hF, 3'b001);
        expectWrite(RESP_OKAY, 16'h0010);
        writeXact(1'b1, 1'b1, 32'h10, 32'h5555AAAA, 4'hF, 3'b001);
        checkOutput("t3_b_valid_held", 64'(bus.b_valid), 64'd1);
        checkOutput("t3_aw_captured", 64'(bus.aw_ready), 64'd0);
        checkOutput("t3_w_captured", 64'(bus.w_ready), 64'd0);
        repeat (3) tick();
        checkOutput("t3_b_valid_still", 64'(bus.b_valid), 64'd1);
        checkOutput("t3_reg4_not_committed", 64'(regAt(4)), 64'd0);
        checkOutput("t3_reg3", 64'(regAt(3)), 64'hC3);
        bus.b_ready = 1'b1;
        tick();
        checkOutput("t3_b_gap", 64'(bus.b_valid), 64'd0);
        tick();
        checkOutput("t3_second_b", 64'(bus.b_valid), 64'd1);
        checkOutput("t3_second_pulse", 64'(wr_pulse), 64'h10);
        checkOutput("t3_reg4", 64'(regAt(4)), 64'h5555AAAA);
        drain();
        expRegs[3] = 32'hC3;
        expRegs[4] = 32'h5555AAAA;

        // 4: out-of-range read and write
        expectRead(RESP_DECERR, 32'h0);
        readXact(32'h40, 3'b001);
        drain();
        expectWrite(RESP_DECERR, 16'h0);
        writeXact(1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 3'b001);
        drain();
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("t4_reg%0d", i), 64'(regAt(i)), 64'(expRegs[i]));

        // 5: back-to-back reads, then R back-pressure
        begin
            logic [31:0] addrs [4];
            addrs[0] = 32'h4; addrs[1] = 32'h8; addrs[2] = 32'hC; addrs[3] = 32'h11;
            expectRead(RESP_OKAY, 32'hAA22CC44);
            expectRead(RESP_OKAY, 32'hDEADBEEF);
            expectRead(RESP_OKAY, 32'h000000C3);
            expectRead(RESP_OKAY, 32'h5555AAAA);
            for (int i = 0; i < 4; i++) begin
                bus.ar_valid = 1'b1; bus.ar_addr = addrs[i]; bus.ar_prot = 3'b001;
                checkOutput($sformatf("t5_ar_ready%0d", i), 64'(bus.ar_ready), 64'd1);
                tick();
                checkOutput($sformatf("t5_r_valid%0d", i), 64'(bus.r_valid), 64'd1);
            end
            bus.ar_valid = 1'b0;
            tick();
            checkOutput("t5_r_idle", 64'(bus.r_valid), 64'd0);
        end
        bus.r_ready = 1'b0;
        expectRead(RESP_OKAY, 32'hDEADBEEF);
        readXact(32'h8, 3'b001);
        expectRead(RESP_OKAY, 32'h000000C3);
        bus.ar_valid = 1'b1; bus.ar_addr = 32'hC; bus.ar_prot = 3'b001;
        #1;
        checkOutput("t5_ar_ready_blocked", 64'(bus.ar_ready), 64'd0);
        tick();
        tick();
        checkOutput("t5_r_data_stable", 64'(bus.r_data), 64'hDEADBEEF);
        checkOutput("t5_ar_ready_still_low", 64'(bus.ar_ready), 64'd0);
        bus.r_ready = 1'b1;
        #1;
        checkOutput("t5_ar_ready_released", 64'(bus.ar_ready), 64'd1);
        tick();
        bus.ar_valid = 1'b0;
        checkOutput("t5_next_r_data", 64'(bus.r_data), 64'hC3);
        drain();

        // 6: protection, then reset with a half-captured write
        expectWrite(PROT_EN ? RESP_SLVERR : RESP_OKAY, PROT_EN ? 16'h0 : 16'h0001);
        writeXact(1'b1, 1'b1, 32'h0, 32'h12345678, 4'hF, 3'b000);
        drain();
        checkOutput("t6_unpriv_reg0", 64'(regAt(0)), PROT_EN ? 64'h0 : 64'h12345678);
        expectWrite(RESP_OKAY, 16'h0001);
        writeXact(1'b1, 1'b1, 32'h0, 32'h00000077, 4'hF, 3'b001);
        drain();
        checkOutput("t6_priv_reg0", 64'(regAt(0)), 64'h77);
        expectRead(PROT_EN ? RESP_SLVERR : RESP_OKAY, PROT_EN ? 32'h0 : 32'h77);
        readXact(32'h0, 3'b000);
        expectRead(RESP_OKAY, 32'h77);
        readXact(32'h0, 3'b001);
        drain();

        bBefore = bSeen;
        writeXact(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 3'b001);
        checkOutput("t6_aw_held", 64'(bus.aw_ready), 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_aw_ready", 64'(bus.aw_ready), 64'd1);
        checkOutput("t6_rst_b_valid", 64'(bus.b_valid), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        bus.w_valid = 1'b0;
        repeat (6) tick();
        checkOutput("t6_no_b_after_rst", 64'(bSeen - bBefore), 64'd0);
        checkOutput("t6_wr_pulse", 64'(wr_pulse), 64'd0);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("t6_rst_reg%0d", i), 64'(regAt(i)), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_prot = '0;
        bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb  = '0;
        bus.b_ready  = 1'b1;
        bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_prot = '0;
        bus.r_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus();
        checkOutput("sb_b_leftover", 64'(bExpQ.size()), 64'd0);
        checkOutput("sb_r_leftover", 64'(rExpQ.size()), 64'd0);
        checkOutput("sb_pulse_leftover", 64'(pulseExpQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
